// File: rtl/srv32_dmem_pkg.sv
// Shared types and window helpers for the srv32 data-memory responder.
// Used by both the RAM and the responder top.
package srv32_dmem_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  strb_t;
  typedef logic [3:0]  wait_cnt_t;

  // Word offset from the window base; only meaningful when in_window() holds.
  function automatic word_t word_idx(input word_t addr, input word_t base);
    return (addr - base) >> 2;
  endfunction

  // The index compare is 33 bits wide so a window reaching 2^32 never wraps.
  function automatic logic in_window(input word_t addr, input word_t base,
                                     input logic [32:0] depth);
    logic [32:0] idx;
    idx = {1'b0, word_idx(addr, base)};
    return (addr >= base) && (idx < depth);
  endfunction

endpackage

// File: rtl/srv32_dmem_ram.sv
// Word RAM with one read and one byte-writable write port.
// Registered read; a same-cycle read and write of one word returns the old contents.
module srv32_dmem_ram
  import srv32_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_W      = 14
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output word_t             q,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  word_t             wdata,
  input  strb_t             wstrb
);

  word_t mem [DEPTH_WORDS];

  // Contents are deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      q <= '0;
    end else if (re) begin
      q <= mem[raddr];
    end
  end

endmodule

// File: rtl/srv32_dmem_responder.sv
// Data-memory slave for the srv32 split read/write channels with per-channel wait states.
// Define DMEM_STATS_EN to add the stat_rd / stat_wr / stat_err access counters.
module srv32_dmem_responder
  import srv32_dmem_pkg::*;
#(
  parameter word_t BASE_ADDR   = 32'h0000_0000,
  parameter int    DEPTH_WORDS = 16384,
  parameter int    RD_WAIT     = 0,
  parameter int    WR_WAIT     = 0
) (
  input  logic  clk,
  input  logic  resetb,
  input  logic  dmem_wready,
  output logic  dmem_wvalid,
  input  word_t dmem_waddr,
  input  word_t dmem_wdata,
  input  strb_t dmem_wstrb,
  input  logic  dmem_rready,
  output logic  dmem_rvalid,
  input  word_t dmem_raddr,
  output logic  dmem_rresp,
  output word_t dmem_rdata
`ifdef DMEM_STATS_EN
  ,
  output word_t stat_rd,
  output word_t stat_wr,
  output word_t stat_err
`endif
);

  // Handshake: the core raises rready/wready with address (and data) stable and
  // holds them; the responder raises rvalid/wvalid combinationally once the wait
  // count is reached, and the transfer happens on the clock edge where both are high.
  // Dropping the request before that edge abandons it.

  localparam int          ADDR_W    = $clog2(DEPTH_WORDS);
  localparam wait_cnt_t   RD_LIM    = wait_cnt_t'(RD_WAIT);
  localparam wait_cnt_t   WR_LIM    = wait_cnt_t'(WR_WAIT);
  localparam logic [32:0] DEPTH_EXT = 33'(DEPTH_WORDS);

  wait_cnt_t         rd_cnt;
  wait_cnt_t         wr_cnt;
  logic              rd_acc;
  logic              wr_acc;
  logic              rd_in;
  logic              wr_in;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] wr_idx;
  logic              rresp_q;
  word_t             ram_q;

  assign dmem_rvalid = dmem_rready && (rd_cnt == RD_LIM);
  assign dmem_wvalid = dmem_wready && (wr_cnt == WR_LIM);
  assign rd_acc      = dmem_rvalid;
  assign wr_acc      = dmem_wvalid;

  assign rd_in  = in_window(dmem_raddr, BASE_ADDR, DEPTH_EXT);
  assign wr_in  = in_window(dmem_waddr, BASE_ADDR, DEPTH_EXT);
  assign rd_idx = ADDR_W'(word_idx(dmem_raddr, BASE_ADDR));
  assign wr_idx = ADDR_W'(word_idx(dmem_waddr, BASE_ADDR));

  // Counters never pass the limit: reaching it with the request held means acceptance.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rd_cnt <= '0;
    end else if (!dmem_rready || rd_acc) begin
      rd_cnt <= '0;
    end else begin
      rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_cnt <= '0;
    end else if (!dmem_wready || wr_acc) begin
      wr_cnt <= '0;
    end else begin
      wr_cnt <= wr_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      rresp_q <= 1'b1;
    end else if (rd_acc) begin
      rresp_q <= rd_in;
    end
  end

  // An out-of-window read leaves the RAM register alone and masks it to zero instead.
  assign dmem_rresp = rresp_q;
  assign dmem_rdata = rresp_q ? ram_q : '0;

  srv32_dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .resetb(resetb),
    .re    (rd_acc && rd_in),
    .raddr (rd_idx),
    .q     (ram_q),
    .we    (wr_acc && wr_in),
    .waddr (wr_idx),
    .wdata (dmem_wdata),
    .wstrb (dmem_wstrb)
  );

`ifdef DMEM_STATS_EN
  logic [1:0] err_inc;

  assign err_inc = {1'b0, rd_acc && !rd_in} + {1'b0, wr_acc && !wr_in};

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_err <= '0;
    end else begin
      if (rd_acc) stat_rd <= stat_rd + 32'd1;
      if (wr_acc) stat_wr <= stat_wr + 32'd1;
      stat_err <= stat_err + {30'd0, err_inc};
    end
  end
`endif

endmodule

// File: tb/tb_srv32_dmem_responder.sv
// Bench for srv32_dmem_responder: a zero-wait instance driven by a vector table and random
// traffic against a word-array model, and a wait-state instance driven by hand sequences.
module tb_srv32_dmem_responder;

  localparam logic [31:0] A_BASE  = 32'h0000_0000;
  localparam int          A_DEPTH = 256;
  localparam logic [31:0] B_BASE  = 32'h0000_1000;
  localparam int          B_DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_resetb, a_wready, a_wvalid, a_rready, a_rvalid, a_rresp;
  logic [31:0] a_waddr, a_wdata, a_raddr, a_rdata;
  logic [3:0]  a_wstrb;
  logic        b_resetb, b_wready, b_wvalid, b_rready, b_rvalid, b_rresp;
  logic [31:0] b_waddr, b_wdata, b_raddr, b_rdata;
  logic [3:0]  b_wstrb;
`ifdef DMEM_STATS_EN
  logic [31:0] a_stat_rd, a_stat_wr, a_stat_err;
  logic [31:0] b_stat_rd, b_stat_wr, b_stat_err;
`endif

  srv32_dmem_responder #(
    .BASE_ADDR(A_BASE), .DEPTH_WORDS(A_DEPTH), .RD_WAIT(0), .WR_WAIT(0)
  ) dut_a (
    .clk(clk), .resetb(a_resetb),
    .dmem_wready(a_wready), .dmem_wvalid(a_wvalid), .dmem_waddr(a_waddr),
    .dmem_wdata(a_wdata), .dmem_wstrb(a_wstrb),
    .dmem_rready(a_rready), .dmem_rvalid(a_rvalid), .dmem_raddr(a_raddr),
    .dmem_rresp(a_rresp), .dmem_rdata(a_rdata)
`ifdef DMEM_STATS_EN
    , .stat_rd(a_stat_rd), .stat_wr(a_stat_wr), .stat_err(a_stat_err)
`endif
  );

  srv32_dmem_responder #(
    .BASE_ADDR(B_BASE), .DEPTH_WORDS(B_DEPTH), .RD_WAIT(3), .WR_WAIT(2)
  ) dut_b (
    .clk(clk), .resetb(b_resetb),
    .dmem_wready(b_wready), .dmem_wvalid(b_wvalid), .dmem_waddr(b_waddr),
    .dmem_wdata(b_wdata), .dmem_wstrb(b_wstrb),
    .dmem_rready(b_rready), .dmem_rvalid(b_rvalid), .dmem_raddr(b_raddr),
    .dmem_rresp(b_rresp), .dmem_rdata(b_rdata)
`ifdef DMEM_STATS_EN
    , .stat_rd(b_stat_rd), .stat_wr(b_stat_wr), .stat_err(b_stat_err)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model for dut_a: word array, expected-read queue, access counters.
  logic [31:0] mem_m [A_DEPTH];
  logic [32:0] exp_q [$];
  logic [32:0] last_exp = {1'b1, 32'h0};
  int n_rd = 0, n_wr = 0, n_err = 0;

  typedef struct {
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rd;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic        exp_rresp;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit a_in_win(input logic [31:0] addr);
    longint a;
    a = longint'(addr);
    return (a >= longint'(A_BASE)) && (a < longint'(A_BASE) + 4 * longint'(A_DEPTH));
  endfunction

  function automatic int a_word(input logic [31:0] addr);
    return int'((longint'(addr) - longint'(A_BASE)) / 4);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One dut_a cycle: drive, check the combinational valids, advance, check the read result.
  task automatic a_cycle(input logic wr, input logic [31:0] waddr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic rd, input logic [31:0] raddr);
    logic [32:0] e;
    int w;
    a_wready = wr; a_waddr = waddr; a_wdata = wdata; a_wstrb = wstrb;
    a_rready = rd; a_raddr = raddr;
    #1;
    check("a_rvalid", {63'd0, a_rvalid}, {63'd0, rd});
    check("a_wvalid", {63'd0, a_wvalid}, {63'd0, wr});
    if (rd) begin
      n_rd++;
      if (a_in_win(raddr)) e = {1'b1, mem_m[a_word(raddr)]};
      else begin e = {1'b0, 32'h0}; n_err++; end
      exp_q.push_back(e);
    end
    if (wr) begin
      n_wr++;
      if (a_in_win(waddr)) begin
        w = a_word(waddr);
        for (int b = 0; b < 4; b++) if (wstrb[b]) mem_m[w][8*b +: 8] = wdata[8*b +: 8];
      end else n_err++;
    end
    tick();
    if (rd && exp_q.size() > 0) last_exp = exp_q.pop_front();
    check("a_rdata", {32'd0, a_rdata}, {32'd0, last_exp[31:0]});
    check("a_rresp", {63'd0, a_rresp}, {63'd0, last_exp[32]});
    a_wready = 1'b0; a_rready = 1'b0;
  endtask

  task automatic check_stats();
`ifdef DMEM_STATS_EN
    check("stat_rd", {32'd0, a_stat_rd}, 64'(n_rd));
    check("stat_wr", {32'd0, a_stat_wr}, 64'(n_wr));
    check("stat_err", {32'd0, a_stat_err}, 64'(n_err));
`endif
  endtask

  // dut_b accesses: the valid must appear exactly on the cycle the wait count allows.
  task automatic b_read(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_r);
    b_rready = 1'b1; b_raddr = addr;
    for (int k = 0; k <= 3; k++) begin
      #1;
      check("b_rvalid_wait", {63'd0, b_rvalid}, {63'd0, k == 3});
      tick();
    end
    b_rready = 1'b0;
    #1;
    check("b_rdata", {32'd0, b_rdata}, {32'd0, exp_d});
    check("b_rresp", {63'd0, b_rresp}, {63'd0, exp_r});
  endtask

  task automatic b_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    b_wready = 1'b1; b_waddr = addr; b_wdata = data; b_wstrb = strb;
    for (int k = 0; k <= 2; k++) begin
      #1;
      check("b_wvalid_wait", {63'd0, b_wvalid}, {63'd0, k == 2});
      tick();
    end
    b_wready = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        32'h0,        1'b1};
    vecs[1]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h100,      32'hDEADBEEF, 1'b1};
    vecs[2]  = '{1'b1, 32'h104, 32'h11223344, 4'hF, 1'b0, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[3]  = '{1'b1, 32'h104, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0,        32'hDEADBEEF, 1'b1};
    vecs[4]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h104,      32'h11BB33DD, 1'b1};
    vecs[5]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h400,      32'h0,        1'b0};
    vecs[6]  = '{1'b1, 32'h000, 32'h12345678, 4'hF, 1'b0, 32'h0,        32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'hFFFFFFFC, 32'h0,        1'b0};
    vecs[8]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 1'b1, 32'h000,      32'h12345678, 1'b1};
    vecs[9]  = '{1'b1, 32'hFFFFFFFC, 32'h0BADF00D, 4'hF, 1'b0, 32'h0,   32'h12345678, 1'b1};
    vecs[10] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h002,      32'h12345678, 1'b1};
    vecs[11] = '{1'b1, 32'h040, 32'h00000001, 4'hF, 1'b0, 32'h0,        32'h12345678, 1'b1};
    vecs[12] = '{1'b1, 32'h040, 32'h00000002, 4'hF, 1'b1, 32'h040,      32'h00000001, 1'b1};
    vecs[13] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h040,      32'h00000002, 1'b1};
    vecs[14] = '{1'b1, 32'h040, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h103,      32'hDEADBEEF, 1'b1};
    vecs[15] = '{1'b0, 32'h0,   32'h0,        4'h0, 1'b1, 32'h043,      32'h00000002, 1'b1};

    a_resetb = 1'b0; a_wready = 1'b0; a_rready = 1'b0;
    a_waddr = '0; a_wdata = '0; a_wstrb = '0; a_raddr = '0;
    b_resetb = 1'b0; b_wready = 1'b0; b_rready = 1'b0;
    b_waddr = '0; b_wdata = '0; b_wstrb = '0; b_raddr = '0;
    repeat (3) @(posedge clk);
    #1;
    a_resetb = 1'b1; b_resetb = 1'b1;
    #1;
    check("rst_a_rdata", {32'd0, a_rdata}, 64'd0);
    check("rst_a_rresp", {63'd0, a_rresp}, 64'd1);
    check("rst_a_valids", {62'd0, a_rvalid, a_wvalid}, 64'd0);
    check("rst_b_rdata", {32'd0, b_rdata}, 64'd0);
    check("rst_b_rresp", {63'd0, b_rresp}, 64'd1);
    check_stats();

    // Directed table on the zero-wait instance.
    for (int i = 0; i < 16; i++) begin
      a_cycle(vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].rd, vecs[i].raddr);
      check($sformatf("tbl%0d_rdata", i), {32'd0, a_rdata}, {32'd0, vecs[i].exp_rdata});
      check($sformatf("tbl%0d_rresp", i), {63'd0, a_rresp}, {63'd0, vecs[i].exp_rresp});
      if (i == 1) check_stats();
    end

    // Fill every word, then random mixed traffic including collisions and out-of-window.
    for (int w = 0; w < A_DEPTH; w++)
      a_cycle(1'b1, A_BASE + 32'(4 * w), $urandom, 4'hF, 1'b0, 32'h0);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ra, wa;
      ra = A_BASE + 4 * $urandom_range(0, A_DEPTH - 1) + $urandom_range(0, 3);
      wa = A_BASE + 4 * $urandom_range(0, A_DEPTH - 1) + $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        0: ra = $urandom_range(32'h400, 32'hFFF);
        1: wa = 32'hFFFF_FF00 | $urandom_range(0, 255);
        2, 3: wa = ra;
        default: ;
      endcase
      a_cycle(1'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), ra);
    end
    check_stats();

    // Wait-state instance: accept timing, abandon/restart, back-to-back, window edges.
    b_write(B_BASE, 32'hCAFE0001, 4'hF);
    b_read(B_BASE, 32'hCAFE0001, 1'b1);
    b_rready = 1'b1; b_raddr = B_BASE + 32'h4;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("b_abandon_rvalid", {63'd0, b_rvalid}, 64'd0);
      tick();
    end
    b_rready = 1'b0;
    #1;
    check("b_abandon_rdata", {32'd0, b_rdata}, {32'd0, 32'hCAFE0001});
    tick();
    b_read(B_BASE - 32'h4, 32'h0, 1'b0);
    b_read(B_BASE + 32'(4 * B_DEPTH), 32'h0, 1'b0);
    b_write(B_BASE + 32'(4 * B_DEPTH), 32'h55555555, 4'hF);
    b_write(B_BASE - 32'h4, 32'h66666666, 4'hF);
    b_read(B_BASE, 32'hCAFE0001, 1'b1);
    tick();
    b_rready = 1'b1; b_raddr = B_BASE;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("b_b2b_rvalid", {63'd0, b_rvalid}, {63'd0, (k == 3) || (k == 7)});
      tick();
    end
    b_rready = 1'b0;
    #1;
    check("b_b2b_rdata", {32'd0, b_rdata}, {32'd0, 32'hCAFE0001});

    // Reset lands while a write is one edge from acceptance.
    tick();
    b_wready = 1'b1; b_waddr = B_BASE; b_wdata = 32'hBAD0BAD0; b_wstrb = 4'hF;
    tick();
    tick();
    check("b_pre_rst_wvalid", {63'd0, b_wvalid}, 64'd1);
    #2;
    b_resetb = 1'b0;
    #1;
    check("b_rst_wvalid", {63'd0, b_wvalid}, 64'd0);
    tick();
    b_wready = 1'b0;
    tick();
    b_resetb = 1'b1;
    #1;
    check("b_rst_rdata", {32'd0, b_rdata}, 64'd0);
    check("b_rst_rresp", {63'd0, b_rresp}, 64'd1);
    tick();
    b_read(B_BASE, 32'hCAFE0001, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Backstop so a wedged run still reports.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
